// File: rtl/pll_rst_ctrl.sv
// ECP5 EHXPLLL bring-up sequencer on the 48 MHz reference clock: pulses PLL RST,
// waits for lock with timeout and retry, debounces lock, then releases core reset.
module pll_rst_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4800,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_losses,
  output logic [2:0] state_dbg
);

  localparam int CMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX   = (CMAX_A > STABLE_CYCLES) ? CMAX_A : STABLE_CYCLES;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW     = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] rtr, rtr_n;
  logic [7:0]    ll_n;
  logic          sync1, lock_s;

  // pll_locked comes from the PLL's own clocking and is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      rtr         <= '0;
      lock_losses <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rtr         <= rtr_n;
      lock_losses <= ll_n;
    end
  end

  // restart is a bare single-cycle request with no handshake; it overrides every
  // state. cnt is cleared on every state change and free-runs otherwise.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    rtr_n   = rtr;
    ll_n    = lock_losses;
    if (restart) begin
      state_n = S_PLL_RST;
      cnt_n   = '0;
      rtr_n   = '0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            rtr_n   = rtr + RW'(1);
            cnt_n   = '0;
            state_n = ((rtr + RW'(1)) == RW'(MAX_RETRIES)) ? S_FAIL : S_PLL_RST;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            state_n = S_RUN;
            cnt_n   = '0;
            rtr_n   = '0;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_n = S_PLL_RST;
            cnt_n   = '0;
            if (lock_losses != 8'hFF) ll_n = lock_losses + 8'd1;
          end
        end
        S_FAIL: begin
          state_n = S_FAIL;
        end
        default: begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
          rtr_n   = '0;
        end
      endcase
    end
  end

  // Moore outputs: core_rst is high whenever pll_rst is, since RUN drives neither.
  assign pll_rst   = (state == S_PLL_RST) || (state == S_FAIL);
  assign core_rst  = (state != S_RUN);
  assign ready     = (state == S_RUN);
  assign fail      = (state == S_FAIL);
  assign state_dbg = state;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scenario bench for pll_rst_ctrl with short timing parameters; expected latencies
// are queued as stimulus is applied and popped when the observed event completes.
module tb_pll_rst_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int BOUND         = 200;

  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_PLL_RST   = 3'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, core_rst, ready, fail;
  logic [7:0] lock_losses;
  logic [2:0] state_dbg;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  pll_rst_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .core_rst   (core_rst),
    .ready      (ready),
    .fail       (fail),
    .lock_losses(lock_losses),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver / measurement tasks ----------------
  task automatic count_pll_rst_high(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < BOUND) begin
      n++;
      tick();
    end
  endtask

  task automatic count_pll_rst_low(output int n);
    n = 0;
    while (pll_rst !== 1'b1 && n < BOUND) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_core_rst(output int n);
    n = 0;
    while (core_rst !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  // Structural invariants checked on every falling edge once out of power-on.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (pll_rst === 1'b1 && core_rst !== 1'b1) begin
        n_fail++;
        $display("FAIL inv_core_rst: core_rst=%b while pll_rst=%b", core_rst, pll_rst);
      end
      n_checks++;
      if (ready === core_rst || ready === 1'bx) begin
        n_fail++;
        $display("FAIL inv_exclusive: ready=%b core_rst=%b", ready, core_rst);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] ev;
    do_reset();
    mon_en = 1'b1;
    exp_q.push_back({20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    ev = exp_q.pop_front();
    n_checks++;
    if ({20'd0, pll_rst, core_rst, ready, fail, lock_losses} !== ev) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h",
               {20'd0, pll_rst, core_rst, ready, fail, lock_losses}, ev);
    end
  endtask

  task automatic test_nominal();
    int n;
    logic [31:0] ev;
    do_reset();
    exp_q.push_back(RST_CYCLES);
    count_pll_rst_high(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL nominal_pulse: got %0d expected %0d", n, ev);
    end
    repeat (10 - RST_CYCLES) tick();
    pll_locked = 1'b1;
    // 2 sync flops, 1 edge to enter STABLE, then the stable window.
    exp_q.push_back(2 + 1 + STABLE_CYCLES);
    wait_ready(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL nominal_ready_latency: got %0d expected %0d", n, ev);
    end
    n_checks++;
    if (core_rst !== 1'b0 || lock_losses !== 8'd0 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_run: core_rst=%b lock_losses=%0d fail=%b expected 0/0/0",
               core_rst, lock_losses, fail);
    end
  endtask

  task automatic test_single_timeout();
    int n;
    logic [31:0] ev;
    do_reset();
    exp_q.push_back(RST_CYCLES);
    exp_q.push_back(LOCK_TIMEOUT);
    exp_q.push_back(RST_CYCLES);
    exp_q.push_back(1 + STABLE_CYCLES);
    count_pll_rst_high(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL timeout_pulse1: got %0d expected %0d", n, ev);
    end
    count_pll_rst_low(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL timeout_window: got %0d expected %0d", n, ev);
    end
    pll_locked = 1'b1;
    count_pll_rst_high(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse2: got %0d fail=%b expected %0d fail=0", n, fail, ev);
    end
    wait_ready(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL timeout_ready_latency: got %0d expected %0d", n, ev);
    end
    // A later lock loss plus one timeout must retry, not fail, since RUN cleared rtr.
    pll_locked = 1'b0;
    exp_q.push_back(3);
    exp_q.push_back(RST_CYCLES);
    exp_q.push_back(LOCK_TIMEOUT);
    exp_q.push_back(RST_CYCLES);
    wait_core_rst(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL retry_loss_latency: got %0d expected %0d", n, ev);
    end
    count_pll_rst_high(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL retry_pulse1: got %0d expected %0d", n, ev);
    end
    count_pll_rst_low(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL retry_window: got %0d expected %0d", n, ev);
    end
    pll_locked = 1'b1;
    count_pll_rst_high(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_pulse2: got %0d fail=%b expected %0d fail=0", n, fail, ev);
    end
    wait_ready(n);
    n_checks++;
    if (ready !== 1'b1 || lock_losses !== 8'd1) begin
      n_fail++;
      $display("FAIL retry_run: ready=%b lock_losses=%0d expected 1/1", ready, lock_losses);
    end
  endtask

  task automatic test_failure();
    int n;
    int held;
    logic [31:0] ev;
    do_reset();
    for (int a = 0; a < MAX_RETRIES; a++) begin
      exp_q.push_back(RST_CYCLES);
      exp_q.push_back(LOCK_TIMEOUT);
      count_pll_rst_high(n);
      ev = exp_q.pop_front();
      n_checks++;
      if (n !== ev) begin
        n_fail++;
        $display("FAIL fail_pulse%0d: got %0d expected %0d", a, n, ev);
      end
      count_pll_rst_low(n);
      ev = exp_q.pop_front();
      n_checks++;
      if (n !== ev) begin
        n_fail++;
        $display("FAIL fail_window%0d: got %0d expected %0d", a, n, ev);
      end
    end
    held = 0;
    repeat (30) begin
      if (fail === 1'b1 && pll_rst === 1'b1 && core_rst === 1'b1 && ready === 1'b0) held++;
      tick();
    end
    exp_q.push_back(30);
    ev = exp_q.pop_front();
    n_checks++;
    if (held !== ev) begin
      n_fail++;
      $display("FAIL fail_hold: held %0d cycles expected %0d", held, ev);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_checks++;
    if (fail !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_restart_clear: fail=%b expected 0", fail);
    end
    exp_q.push_back(RST_CYCLES);
    count_pll_rst_high(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL fail_restart_pulse: got %0d expected %0d", n, ev);
    end
  endtask

  task automatic test_stable_glitch();
    int n;
    logic [31:0] ev;
    do_reset();
    pll_locked = 1'b1;
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    exp_q.push_back({29'd0, ST_STABLE});
    exp_q.push_back({29'd0, ST_WAIT_LOCK});
    exp_q.push_back(1 + STABLE_CYCLES);
    tick();
    ev = exp_q.pop_front();
    n_checks++;
    if ({29'd0, state_dbg} !== ev || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_in_stable: state=%0d ready=%b expected %0d/0", state_dbg, ready, ev);
    end
    tick();
    ev = exp_q.pop_front();
    n_checks++;
    if ({29'd0, state_dbg} !== ev || pll_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_back_wait: state=%0d pll_rst=%b expected %0d/0", state_dbg, pll_rst, ev);
    end
    wait_ready(n);
    ev = exp_q.pop_front();
    n_checks++;
    if (n !== ev) begin
      n_fail++;
      $display("FAIL glitch_ready_latency: got %0d expected %0d", n, ev);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    logic [31:0] ev;
    do_reset();
    pll_locked = 1'b1;
    wait_ready(n);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 6)) tick();
      pll_locked = 1'b0;
      exp_q.push_back(3);
      exp_q.push_back(RST_CYCLES);
      wait_core_rst(n);
      ev = exp_q.pop_front();
      n_checks++;
      if (n !== ev) begin
        n_fail++;
        $display("FAIL loss%0d_core_rst_latency: got %0d expected %0d", k, n, ev);
      end
      count_pll_rst_high(n);
      ev = exp_q.pop_front();
      n_checks++;
      if (n !== ev) begin
        n_fail++;
        $display("FAIL loss%0d_pulse: got %0d expected %0d", k, n, ev);
      end
      pll_locked = 1'b1;
      wait_ready(n);
    end
    exp_q.push_back(3);
    ev = exp_q.pop_front();
    n_checks++;
    if ({24'd0, lock_losses} !== ev) begin
      n_fail++;
      $display("FAIL loss_count: got %0d expected %0d", lock_losses, ev);
    end
    // Restart on the very edge that sees lock_s fall: no loss is counted.
    pll_locked = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_q.push_back({21'd0, 8'd3, ST_PLL_RST});
    ev = exp_q.pop_front();
    n_checks++;
    if ({21'd0, lock_losses, state_dbg} !== ev) begin
      n_fail++;
      $display("FAIL loss_restart: lock_losses=%0d state=%0d expected 3/%0d",
               lock_losses, state_dbg, ST_PLL_RST);
    end
  endtask

  task automatic test_mid_rst();
    int n;
    logic [31:0] ev;
    pll_locked = 1'b1;
    n = 0;
    while (state_dbg !== ST_STABLE && n < BOUND) begin
      tick();
      n++;
    end
    n_checks++;
    if (state_dbg !== ST_STABLE || lock_losses === 8'd0) begin
      n_fail++;
      $display("FAIL midrst_setup: state=%0d lock_losses=%0d expected %0d/nonzero",
               state_dbg, lock_losses, ST_STABLE);
    end
    rst = 1'b1;
    tick();
    exp_q.push_back({20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    ev = exp_q.pop_front();
    n_checks++;
    if ({20'd0, pll_rst, core_rst, ready, fail, lock_losses} !== ev) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h expected %h",
               {20'd0, pll_rst, core_rst, ready, fail, lock_losses}, ev);
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_single_timeout();
    test_failure();
    test_stable_glitch();
    test_lock_loss();
    test_mid_rst();
    tick();
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
